// File: rtl/src_pkg.sv
// Shared definitions for the SRC register-select/encode stage: IR field
// positions, register-file geometry and the immediate sign-extension helper.
package src_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_SEL_W = 4;
  localparam int DATA_W    = 32;

  // Most-significant bit of each IR field; register fields are REG_SEL_W wide
  localparam int RA_MSB = 26;
  localparam int RB_MSB = 22;
  localparam int RC_MSB = 18;
  localparam int C_MSB  = 18;

  // Immediate C occupies IR[C_MSB:0] and is sign-extended to the full data width
  function automatic logic [DATA_W-1:0] sign_ext_c(input logic [DATA_W-1:0] ir);
    return {{(DATA_W-1-C_MSB){ir[C_MSB]}}, ir[C_MSB:0]};
  endfunction

endpackage

// File: rtl/sel_enc_if.sv
// Bus between the control sequencer/register file and the select/encode stage.
// The master side drives the Gr*/Rin/Rout/BAout strobes and the IR; the slave
// side returns the one-hot enables and the sign-extended immediate.
interface sel_enc_if;
  import src_pkg::*;

  logic                 Gra;
  logic                 Grb;
  logic                 Grc;
  logic                 Rin;
  logic                 Rout;
  logic                 BAout;
  logic [DATA_W-1:0]    IR;
  logic [NUM_REGS-1:0]  Rins;
  logic [NUM_REGS-1:0]  Routs;
  logic [DATA_W-1:0]    C_sign_ext;

  modport master (
    output Gra, Grb, Grc, Rin, Rout, BAout, IR,
    input  Rins, Routs, C_sign_ext
  );

  modport slave (
    input  Gra, Grb, Grc, Rin, Rout, BAout, IR,
    output Rins, Routs, C_sign_ext
  );

endinterface

// File: rtl/dec4to16.sv
// Combinational 4-to-16 one-hot decoder; exactly one output bit is always set.
module dec4to16
  import src_pkg::*;
(
  input  logic [REG_SEL_W-1:0] sel,
  output logic [NUM_REGS-1:0]  dec
);

  // Shift a single one into the position named by sel
  always_comb begin
    dec = NUM_REGS'(1) << sel;
  end

endmodule

// File: rtl/sel_enc.sv
// Register-select/encode stage: ORs the IR register fields chosen by Gr*,
// decodes the result to one-hot write/read enables for the 16-entry register
// file, and sign-extends immediate C. All outputs are registered.
module sel_enc
  import src_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  sel_enc_if.slave bus
);

  logic [REG_SEL_W-1:0] sel;
  logic [NUM_REGS-1:0]  dec;
  logic                 out_en;
  logic                 unused_ir;

  // IR[31:27] carries the opcode, which this stage does not look at
  assign unused_ir = ^bus.IR[DATA_W-1:RA_MSB+1];

  // Fields are ORed without priority; with no Gr* strobe the select falls to R0
  always_comb begin
    sel = ({REG_SEL_W{bus.Gra}} & bus.IR[RA_MSB -: REG_SEL_W])
        | ({REG_SEL_W{bus.Grb}} & bus.IR[RB_MSB -: REG_SEL_W])
        | ({REG_SEL_W{bus.Grc}} & bus.IR[RC_MSB -: REG_SEL_W]);
    out_en = bus.Rout | bus.BAout;
  end

  dec4to16 u_dec (
    .sel (sel),
    .dec (dec)
  );

  // Register the gated enables and the extended immediate; reset clears all
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.Rins       <= '0;
      bus.Routs      <= '0;
      bus.C_sign_ext <= '0;
    end else begin
      bus.Rins       <= bus.Rin ? dec : '0;
      bus.Routs      <= out_en  ? dec : '0;
      bus.C_sign_ext <= sign_ext_c(bus.IR);
    end
  end

endmodule

// File: tb/tb_sel_enc.sv
// Directed bench for sel_enc: a table of hand-computed vectors plus short
// sequences for reset behaviour and one-cycle latency.
module tb_sel_enc;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  sel_enc_if bus ();

  sel_enc dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        gra, grb, grc, rin, rout, baout;
    logic [31:0] ir;
    logic [15:0] exp_rins;
    logic [15:0] exp_routs;
    logic [31:0] exp_c;
  } vec_t;

  vec_t vecs [9];

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.Gra   = v.gra;
    bus.Grb   = v.grb;
    bus.Grc   = v.grc;
    bus.Rin   = v.rin;
    bus.Rout  = v.rout;
    bus.BAout = v.baout;
    bus.IR    = v.ir;
  endtask

  task automatic check_all(input string tag, input logic [15:0] rins,
                           input logic [15:0] routs, input logic [31:0] c);
    check_output({tag, ".Rins"},       {16'h0, bus.Rins},  {16'h0, rins});
    check_output({tag, ".Routs"},      {16'h0, bus.Routs}, {16'h0, routs});
    check_output({tag, ".C_sign_ext"}, bus.C_sign_ext,     c);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //          gra  grb  grc  rin  rout baout ir            rins     routs    c
    vecs[0] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 32'h0771000F, 16'h0000,16'h4000,32'h0001000F};
    vecs[1] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0771000F, 16'h0004,16'h0000,32'h0001000F};
    vecs[2] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0007FFFF, 16'h0000,16'h0001,32'hFFFFFFFF};
    vecs[3] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0, 32'h01A00000, 16'h0080,16'h0080,32'h00000000};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 32'h00040000, 16'h0100,16'h0100,32'hFFFC0000};
    vecs[5] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 32'h07800000, 16'h0000,16'h8000,32'h00000000};
    vecs[6] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 32'hFFFFFFFF, 16'h0000,16'h0000,32'hFFFFFFFF};
    vecs[7] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 32'h0003FFFF, 16'h0080,16'h0000,32'h0003FFFF};
    vecs[8] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 32'h00080000, 16'h0000,16'h0002,32'h00000000};

    // Reset asserted with busy inputs, checked before any clock edge
    reset_n = 1'b1;
    apply_stimulus(vecs[3]);
    #1 reset_n = 1'b0;
    #1 check_all("reset_async", 16'h0000, 16'h0000, 32'h0);

    // Reset held across a clock edge keeps outputs cleared
    @(posedge clk);
    #1 check_all("reset_hold", 16'h0000, 16'h0000, 32'h0);

    // Release away from the edge; the next edge loads the current inputs
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(vecs[0]);

    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        @(negedge clk);
        apply_stimulus(vecs[i]);
      end
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", i), vecs[i].exp_rins, vecs[i].exp_routs, vecs[i].exp_c);
    end

    // Latency: ra=5 registered, then ra=9 presented mid-cycle
    @(negedge clk);
    bus.Gra = 1'b1; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.Rin = 1'b0; bus.Rout = 1'b1; bus.BAout = 1'b0;
    bus.IR  = 32'h02800000;
    @(posedge clk);
    #1 check_all("lat_first", 16'h0000, 16'h0020, 32'h0);
    @(negedge clk);
    bus.IR = 32'h04800000;
    #1 check_all("lat_hold", 16'h0000, 16'h0020, 32'h0);
    @(posedge clk);
    #1 check_all("lat_update", 16'h0000, 16'h0200, 32'h0);

    // Reset asserted mid-cycle clears outputs immediately
    #2 reset_n = 1'b0;
    #1 check_all("reset_mid", 16'h0000, 16'h0000, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(vecs[4]);
    @(posedge clk);
    #1 check_all("reset_release", 16'h0100, 16'h0100, 32'hFFFC0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
